spi_rx_fifo: RTL and testbench

- Parametrised SPI slave receiver; successor to the fixed 8-bit, mode-0 receiver.
- Adds configurable word width, all four SPI modes, MSB/LSB-first order, an on-chip receive FIFO with overrun reporting, and a defined reset.
- Sits between the external SPI master pins and the measurement-sample consumer logic in the compressive-sensing datapath.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_rx_sync_fifo.sv | 45 ++++
 rtl/spi_rx_fifo.sv | 91 +++++++++
 tb/tb_spi_rx_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI mode encodings, receiver FSM states and FIFO count width helper
package spi_pkg;
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;
  typedef enum logic {IDLE, ACTIVE} spi_rx_state_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/spi_rx_sync_fifo.sv
// spi_rx_sync_fifo: single-clock first-word-fall-through FIFO
// Ports: clk/rst (async high), push/din write side, pop read side (ignored when empty),
// dout head word, count occupancy 0..DEPTH, full/empty status.
module spi_rx_sync_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          dout,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: parametrised SPI slave receiver (any mode, MSB/LSB first) feeding a receive FIFO
// Ports: clk/rst (async high); sck/ssel/mosi async SPI pins; rd_en pops head, clr_ovr clears
// sticky flags; rd_data FWFT head, rd_valid not empty, fifo_count occupancy, overrun sticky drop
// flag, busy synchronised select. Define SPI_RX_FRAME_ERR_EN to add sticky frame_err output.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sck,
  input  logic                    ssel,
  input  logic                    mosi,
  input  logic                    rd_en,
  input  logic                    clr_ovr,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  output logic [cnt_w(DEPTH)-1:0] fifo_count,
  output logic                    overrun,
`ifdef SPI_RX_FRAME_ERR_EN
  output logic                    frame_err,
`endif
  output logic                    busy
);
  localparam int BW = $clog2(WIDTH);
  logic [2:0] sck_s, ssel_s;
  logic [1:0] mosi_s;
  spi_rx_state_t state, nstate;
  logic [BW-1:0] bitcnt;
  logic [WIDTH-1:0] shreg;
  logic word_done, sample, shift_en, last, full, empty, drop;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s <= {3{CPOL != 0}};
      ssel_s <= '1;
      mosi_s <= '0;
    end else begin
      sck_s <= {sck_s[1:0], sck};
      ssel_s <= {ssel_s[1:0], ssel};
      mosi_s <= {mosi_s[0], mosi};
    end
  end
  // first edge is the sample edge for CPHA=0; with CPOL=1 the first edge is falling
  assign sample = (CPOL == CPHA) ? (sck_s[1] & ~sck_s[2]) : (~sck_s[1] & sck_s[2]);
  assign last = bitcnt == BW'(WIDTH - 1);
  assign busy = ~ssel_s[2];
  assign rd_valid = ~empty;
  assign drop = word_done & full & ~rd_en;
  always_comb begin
    nstate = ssel_s[2] ? IDLE : ACTIVE;
    shift_en = (state == ACTIVE) & ~ssel_s[2] & sample;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bitcnt <= '0;
      shreg <= '0;
      word_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= nstate;
      bitcnt <= (state == IDLE) ? '0 : shift_en ? (last ? '0 : BW'(bitcnt + 1'b1)) : bitcnt;
      shreg <= !shift_en ? shreg :
               (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], mosi_s[1]} : {mosi_s[1], shreg[WIDTH-1:1]};
      word_done <= shift_en & last;
      overrun <= drop | (overrun & ~clr_ovr);
    end
  end
`ifdef SPI_RX_FRAME_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err <= 1'b0;
    else frame_err <= (state == ACTIVE && ssel_s[2] && bitcnt != '0) | (frame_err & ~clr_ovr);
  end
`endif
  spi_rx_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(word_done),
    .din(shreg),
    .pop(rd_en),
    .dout(rd_data),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb_spi_rx_fifo: four receivers (modes 0..3) driven by one SPI master model, checked against queues
module tb_spi_rx_fifo;
  import spi_pkg::*;
  logic clk = 1'b0, rst = 1'b1, sck0 = 1'b0, mosi = 1'b0, sck1;
  logic ssel [4], rd_en [4], clr [4], rv [4], ovr [4], busy [4];
  logic [7:0] rdata [4];
  logic [2:0] cnt0;
  logic [4:0] cnt1, cnt2, cnt3;
`ifdef SPI_RX_FRAME_ERR_EN
  logic ferr [4];
`endif
  logic [7:0] mq [4][$];
  bit movr [4];
  bit mferr [4];
  int dep [4] = '{4, 16, 16, 16};
  int checks = 0, errors = 0;
  assign sck1 = ~sck0;
  always #5 clk = ~clk;

  spi_rx_fifo #(.WIDTH(8), .DEPTH(4), .CPOL(int'(SPI_MODE0[1])), .CPHA(int'(SPI_MODE0[0])), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .sck(sck0), .ssel(ssel[0]), .mosi(mosi), .rd_en(rd_en[0]), .clr_ovr(clr[0]),
    .rd_data(rdata[0]), .rd_valid(rv[0]), .fifo_count(cnt0), .overrun(ovr[0]),
`ifdef SPI_RX_FRAME_ERR_EN
    .frame_err(ferr[0]),
`endif
    .busy(busy[0]));
  spi_rx_fifo #(.WIDTH(8), .DEPTH(16), .CPOL(int'(SPI_MODE1[1])), .CPHA(int'(SPI_MODE1[0])), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .sck(sck0), .ssel(ssel[1]), .mosi(mosi), .rd_en(rd_en[1]), .clr_ovr(clr[1]),
    .rd_data(rdata[1]), .rd_valid(rv[1]), .fifo_count(cnt1), .overrun(ovr[1]),
`ifdef SPI_RX_FRAME_ERR_EN
    .frame_err(ferr[1]),
`endif
    .busy(busy[1]));
  spi_rx_fifo #(.WIDTH(8), .DEPTH(16), .CPOL(int'(SPI_MODE2[1])), .CPHA(int'(SPI_MODE2[0])), .MSB_FIRST(1)) u2 (
    .clk(clk), .rst(rst), .sck(sck1), .ssel(ssel[2]), .mosi(mosi), .rd_en(rd_en[2]), .clr_ovr(clr[2]),
    .rd_data(rdata[2]), .rd_valid(rv[2]), .fifo_count(cnt2), .overrun(ovr[2]),
`ifdef SPI_RX_FRAME_ERR_EN
    .frame_err(ferr[2]),
`endif
    .busy(busy[2]));
  spi_rx_fifo #(.WIDTH(8), .DEPTH(16), .CPOL(int'(SPI_MODE3[1])), .CPHA(int'(SPI_MODE3[0])), .MSB_FIRST(0)) u3 (
    .clk(clk), .rst(rst), .sck(sck1), .ssel(ssel[3]), .mosi(mosi), .rd_en(rd_en[3]), .clr_ovr(clr[3]),
    .rd_data(rdata[3]), .rd_valid(rv[3]), .fifo_count(cnt3), .overrun(ovr[3]),
`ifdef SPI_RX_FRAME_ERR_EN
    .frame_err(ferr[3]),
`endif
    .busy(busy[3]));

  function automatic int cnt_of(input int d);
    return d == 0 ? int'(cnt0) : d == 1 ? int'(cnt1) : d == 2 ? int'(cnt2) : int'(cnt3);
  endfunction

  // one SPI frame: data changes mid-way between sample and launch edges, valid for every mode
  task automatic send(input int d, input logic [7:0] w, input int nbits);
    @(negedge clk);
    ssel[d] = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      mosi = (d == 3) ? w[i] : w[7-i];
      #40 sck0 = 1'b1;
      #80 sck0 = 1'b0;
      #40;
    end
    ssel[d] = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    if (nbits == 8) begin
      if (mq[d].size() == dep[d]) movr[d] = 1'b1;
      else mq[d].push_back(w);
    end else if (nbits != 0) mferr[d] = 1'b1;
  endtask

  task automatic pop(input int d);
    rd_en[d] = 1'b1;
    @(negedge clk);
    rd_en[d] = 1'b0;
    if (mq[d].size() != 0) void'(mq[d].pop_front());
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks += 4;
      if (rv[d] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", d, rv[d]); end
      if (cnt_of(d) !== 0) begin errors++; $display("FAIL reset_count[%0d]: got %0d expected 0", d, cnt_of(d)); end
      if (ovr[d] !== 1'b0) begin errors++; $display("FAIL reset_overrun[%0d]: got %b expected 0", d, ovr[d]); end
      if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy[d]); end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0();
    send(0, 8'hA5, 8);
    checks += 3;
    if (rv[0] !== 1'b1) begin errors++; $display("FAIL m0_valid: got %b expected 1", rv[0]); end
    if (rdata[0] !== 8'hA5) begin errors++; $display("FAIL m0_data: got %h expected a5", rdata[0]); end
    if (cnt0 !== 3'd1) begin errors++; $display("FAIL m0_count: got %0d expected 1", cnt0); end
    pop(0);
    checks += 2;
    if (cnt0 !== 3'd0) begin errors++; $display("FAIL m0_count_pop: got %0d expected 0", cnt0); end
    if (rv[0] !== 1'b0) begin errors++; $display("FAIL m0_valid_pop: got %b expected 0", rv[0]); end
    for (int i = 0; i < 3; i++) send(0, 8'($urandom_range(255)), 8);
    while (mq[0].size() != 0) begin
      checks += 2;
      if (cnt_of(0) !== mq[0].size()) begin errors++; $display("FAIL m0_rand_count: got %0d expected %0d", cnt_of(0), mq[0].size()); end
      if (rdata[0] !== mq[0][0]) begin errors++; $display("FAIL m0_rand_data: got %h expected %h", rdata[0], mq[0][0]); end
      pop(0);
    end
  endtask

  task automatic test_modes();
    send(3, 8'h0D, 8);
    send(1, 8'h3C, 8);
    send(2, 8'h3C, 8);
    checks += 3;
    if (rdata[3] !== 8'h0D) begin errors++; $display("FAIL m3_lsb_data: got %h expected 0d", rdata[3]); end
    if (rdata[1] !== 8'h3C) begin errors++; $display("FAIL m1_data: got %h expected 3c", rdata[1]); end
    if (rdata[2] !== 8'h3C) begin errors++; $display("FAIL m2_data: got %h expected 3c", rdata[2]); end
    for (int i = 0; i < 6; i++) send(1 + i % 3, 8'($urandom_range(255)), 8);
    for (int d = 1; d < 4; d++) begin
      while (mq[d].size() != 0) begin
        checks += 3;
        if (rv[d] !== 1'b1) begin errors++; $display("FAIL mode_valid[%0d]: got %b expected 1", d, rv[d]); end
        if (cnt_of(d) !== mq[d].size()) begin errors++; $display("FAIL mode_count[%0d]: got %0d expected %0d", d, cnt_of(d), mq[d].size()); end
        if (rdata[d] !== mq[d][0]) begin errors++; $display("FAIL mode_data[%0d]: got %h expected %h", d, rdata[d], mq[d][0]); end
        pop(d);
      end
      checks += 2;
      if (rv[d] !== 1'b0) begin errors++; $display("FAIL mode_empty[%0d]: got %b expected 0", d, rv[d]); end
      if (ovr[d] !== movr[d]) begin errors++; $display("FAIL mode_overrun[%0d]: got %b expected %b", d, ovr[d], movr[d]); end
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send(0, 8'(i), 8);
    checks += 2;
    if (cnt0 !== 3'd4) begin errors++; $display("FAIL ovr_count: got %0d expected 4", cnt0); end
    if (ovr[0] !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", ovr[0]); end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rdata[0] !== 8'(i)) begin errors++; $display("FAIL ovr_data: got %h expected %h", rdata[0], 8'(i)); end
      pop(0);
    end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    movr[0] = 1'b0;
    checks++;
    if (ovr[0] !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", ovr[0]); end
    for (int i = 0; i < 6; i++) send(0, 8'($urandom_range(255)), 8);
    checks++;
    if (ovr[0] !== movr[0]) begin errors++; $display("FAIL ovr_rand_flag: got %b expected %b", ovr[0], movr[0]); end
    while (mq[0].size() != 0) begin
      checks++;
      if (rdata[0] !== mq[0][0]) begin errors++; $display("FAIL ovr_rand_data: got %h expected %h", rdata[0], mq[0][0]); end
      pop(0);
    end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    movr[0] = 1'b0;
  endtask

  task automatic test_abort();
    send(0, 8'($urandom_range(255)), 5);
    send(0, 8'h81, 8);
    checks += 2;
    if (cnt0 !== 3'd1) begin errors++; $display("FAIL abort_count: got %0d expected 1", cnt0); end
    if (rdata[0] !== 8'h81) begin errors++; $display("FAIL abort_data: got %h expected 81", rdata[0]); end
`ifdef SPI_RX_FRAME_ERR_EN
    checks++;
    if (ferr[0] !== mferr[0]) begin errors++; $display("FAIL abort_frame_err: got %b expected %b", ferr[0], mferr[0]); end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    mferr[0] = 1'b0;
    checks++;
    if (ferr[0] !== 1'b0) begin errors++; $display("FAIL frame_err_clear: got %b expected 0", ferr[0]); end
`endif
    pop(0);
  endtask

  task automatic test_reset_mid();
    send(0, 8'($urandom_range(255)), 8);
    send(0, 8'($urandom_range(255)), 8);
    @(negedge clk);
    ssel[0] = 1'b0;
    #80;
    for (int i = 0; i < 3; i++) begin
      mosi = 1'($urandom_range(1));
      #40 sck0 = 1'b1;
      #80 sck0 = 1'b0;
      #40;
    end
    rst = 1'b1;
    #1;
    checks += 4;
    if (rv[0] !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", rv[0]); end
    if (cnt0 !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", cnt0); end
    if (ovr[0] !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b expected 0", ovr[0]); end
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy[0]); end
    ssel[0] = 1'b1;
    for (int d = 0; d < 4; d++) begin
      mq[d].delete();
      movr[d] = 1'b0;
      mferr[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(0, 8'h7E, 8);
    checks += 2;
    if (rdata[0] !== 8'h7E) begin errors++; $display("FAIL rstmid_data: got %h expected 7e", rdata[0]); end
    if (cnt0 !== 3'd1) begin errors++; $display("FAIL rstmid_count2: got %0d expected 1", cnt0); end
    pop(0);
  endtask

  initial begin
    ssel = '{default: 1'b1};
    rd_en = '{default: 1'b0};
    clr = '{default: 1'b0};
    test_reset();
    test_mode0();
    test_modes();
    test_overrun();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
